// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue/writeback stage: ALU function codes,
// FSM state encodings and default sizing.
package alu_issue_pkg;

    localparam int DMEM_DATA_WIDTH = 16;
    localparam int ISSUE_NUM_REGS  = 8;

    localparam logic [2:0] ALU_FUNC_ADD = 3'd0;
    localparam logic [2:0] ALU_FUNC_SUB = 3'd1;
    localparam logic [2:0] ALU_FUNC_AND = 3'd2;
    localparam logic [2:0] ALU_FUNC_OR  = 3'd3;
    localparam logic [2:0] ALU_FUNC_XOR = 3'd4;
    localparam logic [2:0] ALU_FUNC_SLL = 3'd5;
    localparam logic [2:0] ALU_FUNC_SRL = 3'd6;

    typedef enum logic [1:0] {
        ISSUE_ST_IDLE = 2'd0,
        ISSUE_ST_EXEC = 2'd1,
        ISSUE_ST_WB   = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue stage: two operand read ports, one debug read
// port and one synchronous write port. r0 is hardwired to zero.
module alu_regfile
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int NUM_REGS   = ISSUE_NUM_REGS,
    parameter int RA_W       = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RA_W-1:0]       raddr1,
    input  logic [RA_W-1:0]       raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic [RA_W-1:0]       dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    input  logic                  we,
    input  logic [RA_W-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

    // Next-state of the array; writes to r0 are dropped so it stays zero.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d[0] = '0;
        end
    end

    // Array storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata1   = (raddr1 == '0)   ? '0 : mem_q[raddr1];
    assign rdata2   = (raddr2 == '0)   ? '0 : mem_q[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand-fetch/issue and writeback stage wrapped around an external
// combinational ALU. One op in flight: IDLE -> EXEC -> WB -> IDLE.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int NUM_REGS   = ISSUE_NUM_REGS,
    parameter int RA_W       = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_func,
    input  logic                  instr_alu_en,
    input  logic [RA_W-1:0]       instr_rd,
    input  logic [RA_W-1:0]       instr_rs1,
    input  logic [RA_W-1:0]       instr_rs2,
    input  logic                  instr_use_imm,
    input  logic [DATA_WIDTH-1:0] instr_imm,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_func,
    output logic                  alu_enable,
    input  logic [DATA_WIDTH-1:0] alu_z,
    output logic                  wb_valid,
    output logic [RA_W-1:0]       wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    input  logic [RA_W-1:0]       dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    issue_state_e          state_q, state_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [2:0]            func_q, func_d;
    logic                  alu_enable_q, alu_enable_d;
    logic [RA_W-1:0]       rd_q, rd_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [RA_W-1:0]       wb_rd_q, wb_rd_d;

    logic [DATA_WIDTH-1:0] rs1_data_s;
    logic [DATA_WIDTH-1:0] rs2_data_s;
    logic                  rf_we_s;

    // The write lands on the WB->IDLE edge, so the next accept sees it.
    assign rf_we_s = (state_q == ISSUE_ST_WB);

    alu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RA_W       (RA_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1   (instr_rs1),
        .raddr2   (instr_rs2),
        .rdata1   (rs1_data_s),
        .rdata2   (rs2_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we_s),
        .waddr    (rd_q),
        .wdata    (result_q)
    );

    // Next-state and output decode for the issue FSM.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        func_d       = func_q;
        rd_d         = rd_q;
        result_d     = result_q;
        wb_rd_d      = wb_rd_q;
        alu_enable_d = 1'b0;
        wb_valid_d   = 1'b0;
        case (state_q)
            ISSUE_ST_IDLE: begin
                if (instr_valid) begin
                    a_d          = rs1_data_s;
                    b_d          = instr_use_imm ? instr_imm : rs2_data_s;
                    func_d       = instr_func;
                    rd_d         = instr_rd;
                    alu_enable_d = instr_alu_en;
                    state_d      = ISSUE_ST_EXEC;
                end else begin
                    state_d = ISSUE_ST_IDLE;
                end
            end
            ISSUE_ST_EXEC: begin
                result_d   = alu_z;
                wb_rd_d    = rd_q;
                wb_valid_d = 1'b1;
                state_d    = ISSUE_ST_WB;
            end
            ISSUE_ST_WB: begin
                state_d = ISSUE_ST_IDLE;
            end
            default: begin
                state_d = ISSUE_ST_IDLE;
            end
        endcase
        ready_d = (state_d == ISSUE_ST_IDLE);
    end

    // FSM state, operand and writeback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ISSUE_ST_IDLE;
            ready_q      <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            func_q       <= 3'd0;
            alu_enable_q <= 1'b0;
            rd_q         <= '0;
            result_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            a_q          <= a_d;
            b_q          <= b_d;
            func_q       <= func_d;
            alu_enable_q <= alu_enable_d;
            rd_q         <= rd_d;
            result_q     <= result_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
        end
    end

    assign instr_ready = ready_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_func    = func_q;
    assign alu_enable  = alu_enable_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = result_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural 16-bit ALU attached.
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_func;
    logic          instr_alu_en;
    logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
    logic          instr_use_imm;
    logic [DW-1:0] instr_imm;
    logic [DW-1:0] alu_a, alu_b, alu_z;
    logic [2:0]    alu_func;
    logic          alu_enable;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue #(.DATA_WIDTH(DW), .NUM_REGS(8), .RA_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_func(instr_func), .instr_alu_en(instr_alu_en),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_enable(alu_enable),
        .alu_z(alu_z),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference ALU: shifts use the full b value, unknown codes give 0.
    always_comb begin
        alu_z = '0;
        if (!alu_enable) begin
            alu_z = alu_a;
        end else begin
            case (alu_func)
                ALU_FUNC_ADD: alu_z = alu_a + alu_b;
                ALU_FUNC_SUB: alu_z = alu_a - alu_b;
                ALU_FUNC_AND: alu_z = alu_a & alu_b;
                ALU_FUNC_OR:  alu_z = alu_a | alu_b;
                ALU_FUNC_XOR: alu_z = alu_a ^ alu_b;
                ALU_FUNC_SLL: alu_z = alu_a << alu_b;
                ALU_FUNC_SRL: alu_z = alu_a >> alu_b;
                default:      alu_z = '0;
            endcase
        end
    end

    typedef struct {
        logic [2:0]    func;
        logic          en;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          use_imm;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [12];
    logic [DW-1:0] exp_regs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr_func    = v.func;
        instr_alu_en  = v.en;
        instr_rd      = v.rd;
        instr_rs1     = v.rs1;
        instr_rs2     = v.rs2;
        instr_use_imm = v.use_imm;
        instr_imm     = v.imm;
        instr_valid   = 1'b1;
    endtask

    // Called #1 after a rising edge with the stage idle; returns #1 after T+3.
    task automatic issue(input vec_t v);
        drive(v);
        check("ready_idle", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("ready_exec", {31'd0, instr_ready}, 32'd0);
        check("alu_enable_exec", {31'd0, alu_enable}, {31'd0, v.en});
        check("wb_valid_exec", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        check("wb_valid_wb", {31'd0, wb_valid}, 32'd1);
        check("wb_rd", {29'd0, wb_rd}, {29'd0, v.rd});
        check("wb_data", {16'd0, wb_data}, {16'd0, v.exp});
        check("ready_wb", {31'd0, instr_ready}, 32'd0);
        check("alu_enable_wb", {31'd0, alu_enable}, 32'd0);
        @(posedge clk); #1;
        check("wb_valid_after", {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int acc;
        int wbc;

        vecs[0]  = '{ALU_FUNC_ADD, 1'b1, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 16'h0005};
        vecs[1]  = '{ALU_FUNC_ADD, 1'b1, 3'd2, 3'd1, 3'd0, 1'b1, 16'h00FF, 16'h0104};
        vecs[2]  = '{ALU_FUNC_ADD, 1'b1, 3'd3, 3'd0, 3'd0, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[3]  = '{ALU_FUNC_ADD, 1'b1, 3'd4, 3'd3, 3'd3, 1'b0, 16'h0000, 16'hFFFE};
        vecs[4]  = '{ALU_FUNC_SUB, 1'b1, 3'd5, 3'd0, 3'd3, 1'b0, 16'h0000, 16'h0001};
        vecs[5]  = '{ALU_FUNC_ADD, 1'b0, 3'd6, 3'd4, 3'd1, 1'b0, 16'h0000, 16'hFFFE};
        vecs[6]  = '{ALU_FUNC_ADD, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234, 16'h1234};
        vecs[7]  = '{ALU_FUNC_ADD, 1'b1, 3'd7, 3'd0, 3'd1, 1'b0, 16'h0000, 16'h0005};
        vecs[8]  = '{ALU_FUNC_SLL, 1'b1, 3'd7, 3'd5, 3'd0, 1'b1, 16'h0004, 16'h0010};
        vecs[9]  = '{ALU_FUNC_SLL, 1'b1, 3'd7, 3'd5, 3'd0, 1'b1, 16'h0010, 16'h0000};
        vecs[10] = '{3'd7,         1'b1, 3'd7, 3'd4, 3'd4, 1'b0, 16'h0000, 16'h0000};
        vecs[11] = '{ALU_FUNC_XOR, 1'b1, 3'd2, 3'd4, 3'd0, 1'b1, 16'h00FF, 16'hFF01};
        exp_regs = '{16'h0000, 16'h0005, 16'hFF01, 16'hFFFF,
                     16'hFFFE, 16'h0001, 16'hFFFE, 16'h0000};

        rst_n = 1'b0;
        instr_valid = 1'b0;
        v = vecs[0];
        drive(v);
        instr_valid = 1'b0;
        dbg_addr = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_alu_enable", {31'd0, alu_enable}, 32'd0);
        check("rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("rst_alu_b", {16'd0, alu_b}, 32'd0);
        check("rst_alu_func", {29'd0, alu_func}, 32'd0);
        check("rst_wb_data", {16'd0, wb_data}, 32'd0);
        check("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i]);
            if (i == 1) begin
                dbg_addr = 3'd2;
                #1;
                check("dbg_r2_early", {16'd0, dbg_data}, 32'h0104);
            end
        end
        for (int r = 0; r < 8; r++) begin
            dbg_addr = r[AW-1:0];
            #1;
            check($sformatf("dbg_r%0d", r), {16'd0, dbg_data}, {16'd0, exp_regs[r]});
        end

        // Valid held for 9 cycles: accepts only at edges 0, 3, 6; r1 counts 5 -> 8.
        v = '{ALU_FUNC_ADD, 1'b1, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0001, 16'h0000};
        drive(v);
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("hs_ready_%0d", i), {31'd0, instr_ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
            if (instr_ready) acc++;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        check("hs_accepts", acc, 32'd3);
        dbg_addr = 3'd1;
        #1;
        check("hs_r1", {16'd0, dbg_data}, 32'h0008);

        // Reset during EXEC abandons the op.
        v = '{ALU_FUNC_ADD, 1'b1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h00AA, 16'h00AA};
        drive(v);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wbc = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_valid) wbc++;
        end
        check("midrst_no_wb", wbc, 32'd0);
        check("midrst_ready", {31'd0, instr_ready}, 32'd1);
        check("midrst_alu_enable", {31'd0, alu_enable}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = r[AW-1:0];
            #1;
            check($sformatf("midrst_r%0d", r), {16'd0, dbg_data}, 32'd0);
        end

        // Debug read during the WB cycle sees the old value.
        dbg_addr = 3'd3;
        v = '{ALU_FUNC_ADD, 1'b1, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0BEE, 16'h0BEE};
        drive(v);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("coll_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("coll_old", {16'd0, dbg_data}, 32'd0);
        @(posedge clk); #1;
        check("coll_new", {16'd0, dbg_data}, 32'h0BEE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
